jk_reg_bank: RTL and testbench
==============================

JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 Parameter: WIDTH, 8, number of JK channels (1..32).
REQ-002 Parameter: CNT_W, 8, width of the change-event counter (2..16).
REQ-003 Parameter: RST_VAL, {WIDTH{1'b0}}, value of q on reset.
REQ-004 Port: clk  input  1  clock; all state updates on the falling edge.
REQ-005 Port: clr_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: ce  input  1  clock enable for JK/counter updates.
REQ-007 Port: mode  input  1  0 = independent JK channels; 1 = synchronous binary up-counter.
REQ-008 Port: load  input  1  synchronous parallel load strobe.
REQ-009 Port: d  input  WIDTH  parallel load data.
REQ-010 Port: j  input  WIDTH  per-channel J.
REQ-011 Port: k  input  WIDTH  per-channel K.
REQ-012 Port: clr_cnt  input  1  synchronous clear of chg_cnt.
REQ-013 Port: q  output  WIDTH  registered channel state.
REQ-014 Port: q_n  output  WIDTH  combinational ~q, with no added delay.
REQ-015 Port: chg  output  WIDTH  registered per-bit flag; 1 where q changed at the last falling edge.
REQ-016 Port: chg_cnt  output  CNT_W  saturating count of edges where any bit of q changed.
REQ-017 Port: tc  output  1  combinational terminal count: mode & ce & (q == all ones).

Function
REQ-018 Update priority each falling edge SHALL be: load, then ce, then hold.
REQ-019 load=1 SHALL set q <= d regardless of ce, mode, j and k.
REQ-020 load=0, ce=0 SHALL hold q.
REQ-021 load=0, ce=1, mode=0: each bit i SHALL follow {j[i],k[i]}: 00 hold, 01 clear to 0, 10 set to 1, 11 toggle.
REQ-022 load=0, ce=1, mode=1: q SHALL increment by 1 modulo 2^WIDTH; bit i toggles iff all lower bits are 1; j and k are ignored.
REQ-023 The counter SHALL wrap from all ones to 0 in one edge, with tc=1 during the cycle before the wrap.
REQ-024 chg SHALL equal (q_next ^ q) latched at the same edge, and SHALL be 0 on edges where q is unchanged (including a load of an equal value).
REQ-025 chg_cnt SHALL increment by 1 on each edge where |(q_next ^ q) and clr_cnt=0.
REQ-026 chg_cnt SHALL saturate at 2^CNT_W-1.
REQ-027 clr_cnt=1 SHALL set chg_cnt to 0 and SHALL win over a simultaneous increment.
REQ-028 A mode change SHALL take effect at the next edge; no state other than q carries over.

Reset
REQ-029 On clr_n=0, the following SHALL apply immediately, without a clock: q=RST_VAL, q_n=~RST_VAL, chg=0, chg_cnt=0.
REQ-030 While clr_n=0, all inputs SHALL be ignored.
REQ-031 The first update after release SHALL occur at the first falling edge with clr_n=1.
REQ-032 A reset asserted mid-count SHALL discard the count and chg history.

Structure
REQ-033 Package jk_reg_bank_pkg SHALL hold the JK op encoding (HOLD=0, RESET=1, SET=2, TOGGLE=3, index {j,k}) and the mode constants (MODE_JK=0, MODE_CNT=1).
REQ-034 Sub-module jk_cell SHALL be the single-bit combinational next-state function (inputs q, j, k, load, d, ce) and SHALL be instantiated WIDTH times.
REQ-035 Counter-mode toggle enables SHALL be generated in the top level and fed to jk_cell as j=k=1.

Verification
REQ-036 WIDTH=8: reset, then release with ce=1, mode=0, j=8'hF0, k=8'h0F for one edge -> q=8'hF0, chg=8'hF0, chg_cnt=1.
REQ-037 q=8'hF0, j=k=8'hFF, then apply a second toggle -> q=8'h0F, then q=8'hF0; chg=8'hFF both edges; chg_cnt +2.
REQ-038 mode=1, load d=8'hFE, then 2 edges with ce=1 -> q=8'hFF with tc=1, then q=8'h00, chg=8'hFF.
REQ-039 CNT_W=2: toggle bit 0 for 5 edges -> chg_cnt goes 1,2,3,3,3; clr_cnt with a change on the same edge -> chg_cnt=0.
REQ-040 load=1, ce=0, d=q -> q unchanged, chg=0, chg_cnt unchanged; load with j=k=FF -> q=d.
REQ-041 Assert clr_n low between edges mid-count -> q, chg and chg_cnt reset immediately; the first falling edge after release updates from RST_VAL.

Source files
------------

// File: rtl/jk_reg_bank_pkg.sv
// jk_reg_bank_pkg: shared JK op encoding and mode constants for the JK register bank
package jk_reg_bank_pkg;
    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        RESET  = 2'd1,
        SET    = 2'd2,
        TOGGLE = 2'd3
    } jk_op_e;
    localparam logic MODE_JK  = 1'b0;
    localparam logic MODE_CNT = 1'b1;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: single-bit next-state function with load > ce > hold priority
module jk_cell
    import jk_reg_bank_pkg::*;
(
    input  logic q,
    input  logic j,
    input  logic k,
    input  logic load,
    input  logic d,
    input  logic ce,
    output logic q_next
);
    jk_op_e op;
    logic   jk;
    always_comb begin
        op     = jk_op_e'({j, k});
        jk     = op == HOLD  ? q :
                 op == RESET ? 1'b0 :
                 op == SET   ? 1'b1 : ~q;
        q_next = load ? d : ce ? jk : q;
    end
endmodule

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: falling-edge JK register bank with counter mode, change flags and change counter
module jk_reg_bank
    import jk_reg_bank_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ce,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] chg,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             tc
);
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] diff;
    genvar b;
    generate
        for (b = 0; b < WIDTH; b++) begin : g_cell
            logic tog;
            logic jj;
            logic kk;
            // In counter mode a bit toggles only when every lower bit is set
            if (b == 0) begin : g_lsb
                assign tog = 1'b1;
            end else begin : g_upper
                assign tog = &q[b-1:0];
            end
            assign jj = (mode == MODE_CNT) ? tog : j[b];
            assign kk = (mode == MODE_CNT) ? tog : k[b];
            jk_cell u_cell (
                .q      (q[b]),
                .j      (jj),
                .k      (kk),
                .load   (load),
                .d      (d[b]),
                .ce     (ce),
                .q_next (q_next[b])
            );
        end
    endgenerate
    assign diff = q_next ^ q;
    assign q_n  = ~q;
    assign tc   = (mode == MODE_CNT) & ce & (&q);
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q       <= RST_VAL;
            chg     <= '0;
            chg_cnt <= '0;
        end else begin
            q       <= q_next;
            chg     <= diff;
            chg_cnt <= clr_cnt ? '0 :
                       ((|diff) && (chg_cnt != {CNT_W{1'b1}})) ? chg_cnt + 1'b1 : chg_cnt;
        end
    end
endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank: table-driven scoreboard bench for jk_reg_bank (CNT_W=8 and CNT_W=2 instances)
module tb_jk_reg_bank;
    logic       clk = 1'b0;
    logic       clr_n, ce, mode, load, clr_cnt;
    logic [7:0] d, j, k;
    logic [7:0] q, q_n, chg, q2, q2_n, chg2;
    logic [7:0] chg_cnt;
    logic [1:0] chg_cnt2;
    logic       tc, tc2;
    int         checks = 0;
    int         failures = 0;

    typedef struct {
        logic       ld, en, md, cc;
        logic [7:0] dd, jj, kk;
        logic [7:0] eq, echg;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] q, chg, cnt;
        logic [1:0] cnt2;
        logic       tc;
    } exp_t;

    exp_t       sb[$];
    vec_t       tbl[22];
    logic [7:0] mq;
    logic [7:0] mcnt;
    logic [1:0] mcnt2;

    jk_reg_bank #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .clr_n(clr_n), .ce(ce), .mode(mode), .load(load), .d(d), .j(j), .k(k),
        .clr_cnt(clr_cnt), .q(q), .q_n(q_n), .chg(chg), .chg_cnt(chg_cnt), .tc(tc)
    );

    jk_reg_bank #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .clr_n(clr_n), .ce(ce), .mode(mode), .load(load), .d(d), .j(j), .k(k),
        .clr_cnt(clr_cnt), .q(q2), .q_n(q2_n), .chg(chg2), .chg_cnt(chg_cnt2), .tc(tc2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector, expect its results after the next falling edge, sample on the rising edge
    task automatic step(input string name, input vec_t v);
        exp_t e;
        e.name = name;
        e.q    = v.eq;
        e.chg  = v.echg;
        mcnt   = v.cc ? 8'd0 : (v.echg != 0 && mcnt != 8'hFF) ? mcnt + 8'd1 : mcnt;
        mcnt2  = v.cc ? 2'd0 : (v.echg != 0 && mcnt2 != 2'd3) ? mcnt2 + 2'd1 : mcnt2;
        e.cnt  = mcnt;
        e.cnt2 = mcnt2;
        e.tc   = v.md & v.en & (v.eq == 8'hFF);
        mq     = v.eq;
        sb.push_back(e);
        load = v.ld; ce = v.en; mode = v.md; clr_cnt = v.cc; d = v.dd; j = v.jj; k = v.kk;
        @(negedge clk);
        @(posedge clk);
        e = sb.pop_front();
        check({e.name, " q"}, q, e.q);
        check({e.name, " q_n"}, q_n, ~e.q);
        check({e.name, " chg"}, chg, e.chg);
        check({e.name, " chg_cnt"}, chg_cnt, e.cnt);
        check({e.name, " chg_cnt2"}, {6'd0, chg_cnt2}, {6'd0, e.cnt2});
        check({e.name, " tc"}, {7'd0, tc}, {7'd0, e.tc});
        check({e.name, " q2"}, q2, e.q);
    endtask

    function automatic vec_t mk(input logic ld, en, md, cc, input logic [7:0] dd, jj, kk, eq, echg);
        vec_t v;
        v.ld = ld; v.en = en; v.md = md; v.cc = cc;
        v.dd = dd; v.jj = jj; v.kk = kk; v.eq = eq; v.echg = echg;
        return v;
    endfunction

    task automatic check_reset(input string name);
        check({name, " q"}, q, 8'h00);
        check({name, " q_n"}, q_n, 8'hFF);
        check({name, " chg"}, chg, 8'h00);
        check({name, " chg_cnt"}, chg_cnt, 8'h00);
        check({name, " chg_cnt2"}, {6'd0, chg_cnt2}, 8'h00);
    endtask

    initial begin
        //            ld en md cc  d      j      k      q      chg
        tbl[0]  = mk(0, 1, 0, 0, 8'h00, 8'hF0, 8'h0F, 8'hF0, 8'hF0);
        tbl[1]  = mk(0, 1, 0, 0, 8'h00, 8'hFF, 8'hFF, 8'h0F, 8'hFF);
        tbl[2]  = mk(0, 1, 0, 0, 8'h00, 8'hFF, 8'hFF, 8'hF0, 8'hFF);
        tbl[3]  = mk(0, 0, 0, 0, 8'h00, 8'hFF, 8'hFF, 8'hF0, 8'h00);
        tbl[4]  = mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h00);
        tbl[5]  = mk(0, 1, 0, 0, 8'h00, 8'h0C, 8'h30, 8'hCC, 8'h3C);
        tbl[6]  = mk(1, 0, 0, 0, 8'hCC, 8'h00, 8'h00, 8'hCC, 8'h00);
        tbl[7]  = mk(1, 1, 1, 0, 8'h5A, 8'hFF, 8'hFF, 8'h5A, 8'h96);
        tbl[8]  = mk(1, 1, 1, 0, 8'hFE, 8'h00, 8'h00, 8'hFE, 8'hA4);
        tbl[9]  = mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h01);
        tbl[10] = mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        tbl[11] = mk(0, 1, 1, 0, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h01);
        tbl[12] = mk(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00);
        tbl[13] = mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h02, 8'h03);
        tbl[14] = mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00);
        tbl[15] = mk(0, 1, 0, 1, 8'h00, 8'h01, 8'h00, 8'h03, 8'h01);
        tbl[16] = mk(0, 1, 0, 0, 8'h00, 8'h01, 8'h01, 8'h02, 8'h01);
        tbl[17] = mk(0, 1, 0, 0, 8'h00, 8'h01, 8'h01, 8'h03, 8'h01);
        tbl[18] = mk(0, 1, 0, 0, 8'h00, 8'h01, 8'h01, 8'h02, 8'h01);
        tbl[19] = mk(0, 1, 0, 0, 8'h00, 8'h01, 8'h01, 8'h03, 8'h01);
        tbl[20] = mk(0, 1, 0, 0, 8'h00, 8'h01, 8'h01, 8'h02, 8'h01);
        tbl[21] = mk(0, 1, 0, 1, 8'h00, 8'h01, 8'h01, 8'h03, 8'h01);

        clr_n = 1'b0; ce = 1'b1; mode = 1'b0; load = 1'b1; clr_cnt = 1'b0;
        d = 8'hAA; j = 8'hFF; k = 8'hFF;
        mq = 8'h00; mcnt = 8'h00; mcnt2 = 2'd0;
        #1;
        check_reset("reset_async");
        @(negedge clk);
        @(posedge clk);
        check_reset("reset_held");
        clr_n = 1'b1;

        for (int i = 0; i < 22; i++) step($sformatf("vec%0d", i), tbl[i]);
        check("cnt_after_table", chg_cnt, 8'h00);

        // Build up some count history, then reset between edges
        step("pre_rst0", mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h04, 8'h07));
        step("pre_rst1", mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h05, 8'h01));
        #2 clr_n = 1'b0;
        #1;
        check_reset("mid_reset");
        mq = 8'h00; mcnt = 8'h00; mcnt2 = 2'd0;
        load = 1'b1; d = 8'h77; ce = 1'b1;
        @(negedge clk);
        @(posedge clk);
        check_reset("mid_reset_held");
        #1 clr_n = 1'b1;
        step("post_rst", mk(0, 1, 0, 0, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01));
        check("post_rst_cnt_abs", chg_cnt, 8'h01);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
        end
        checks++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
